// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO: configurable data width, parity and stop bits.
// Queued words go out as contiguous frames, LSB first, line idle high.
module uart_tx_fifo #(
    parameter int unsigned CLOCKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               out_tx,
    output logic                               out_tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    out_fifo_count
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CCW = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 2);

    // Reject unsupported frame/FIFO configurations at elaboration time
    if (CLOCKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [CCW-1:0]       cyc_cnt, cyc_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 par_bit, par_n;
    logic                 tx_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 push_c, pop_c, last_cyc_c, fifo_nonempty_c;
    logic [DATA_BITS-1:0] head_c;

    assign tx_ready        = (out_fifo_count != CW'(FIFO_DEPTH));
    assign fifo_nonempty_c = (out_fifo_count != '0);
    assign out_tx_busy     = (state != S_IDLE) || fifo_nonempty_c;
    assign push_c          = tx_valid && tx_ready;
    assign head_c          = mem[rd_ptr];
    assign last_cyc_c      = (cyc_cnt == CCW'(CLOCKS_PER_BIT - 1));

    // Next-state and next-line logic; a frame start pops the FIFO head
    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        par_n   = par_bit;
        tx_n    = out_tx;
        pop_c   = 1'b0;

        if (state != S_IDLE) begin
            cyc_n = last_cyc_c ? '0 : cyc_cnt + CCW'(1);
        end

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (fifo_nonempty_c) begin
                    pop_c = 1'b1;
                end
            end
            S_START: begin
                if (last_cyc_c) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            S_DATA: begin
                if (last_cyc_c) begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_n = '0;
                        if (PAR_EN) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                        sh_n  = shreg >> 1;
                        tx_n  = shreg[1];
                    end
                end
            end
            S_PARITY: begin
                if (last_cyc_c) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                if (last_cyc_c) begin
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        bit_n = '0;
                        if (fifo_nonempty_c) begin
                            pop_c = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Back-to-back start: load the next word the same edge the previous frame ends
        if (pop_c) begin
            state_n = S_START;
            cyc_n   = '0;
            bit_n   = '0;
            sh_n    = head_c;
            par_n   = (^head_c) ^ PAR_ODD;
            tx_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cyc_cnt        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
            out_tx         <= 1'b1;
            out_fifo_count <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            state          <= state_n;
            cyc_cnt        <= cyc_n;
            bit_cnt        <= bit_n;
            shreg          <= sh_n;
            par_bit        <= par_n;
            out_tx         <= tx_n;
            out_fifo_count <= out_fifo_count + CW'(push_c) - CW'(pop_c);
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats run side by side against a
// frame-level reference model (word queue + expected line waveform).
module tb_uart_tx_fifo;

    localparam int NI    = 4;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DB  [NI] = '{8, 8, 8, 7};
    localparam int PAR [NI] = '{0, 1, 2, 0};
    localparam int SB  [NI] = '{1, 1, 1, 2};

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0][8:0] data;
    logic [NI-1:0]      valid;
    logic [NI-1:0]      tx, busy, ready;
    logic [NI-1:0][2:0] cnt;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(data[0][7:0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .out_tx(tx[0]), .out_tx_busy(busy[0]), .out_fifo_count(cnt[0]));
    uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(data[1][7:0]), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .out_tx(tx[1]), .out_tx_busy(busy[1]), .out_fifo_count(cnt[1]));
    uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(data[2][7:0]), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .out_tx(tx[2]), .out_tx_busy(busy[2]), .out_fifo_count(cnt[2]));
    uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_data(data[3][6:0]), .tx_valid(valid[3]), .tx_ready(ready[3]),
        .out_tx(tx[3]), .out_tx_busy(busy[3]), .out_fifo_count(cnt[3]));

    // Reference model: pending words, and the frame currently on the line
    logic [8:0]  mq [NI][DEPTH];
    int          mq_n   [NI];
    logic [15:0] fr     [NI];
    int          fr_tot [NI];
    int          fr_cyc [NI];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NI; i++) begin
            mq_n[i]   = 0;
            fr_tot[i] = 0;
            fr_cyc[i] = 0;
        end
    endfunction

    function automatic void model_edge(input int i, input logic v, input logic [8:0] d);
        logic       rdy;
        logic [8:0] w;
        logic [8:0] mask;
        int         nb;
        rdy  = (mq_n[i] != DEPTH);
        mask = 9'((1 << DB[i]) - 1);
        if (fr_cyc[i] < fr_tot[i]) fr_cyc[i]++;
        if (fr_cyc[i] >= fr_tot[i] && mq_n[i] > 0) begin
            w = mq[i][0];
            for (int k = 1; k < DEPTH; k++) mq[i][k-1] = mq[i][k];
            mq_n[i]--;
            fr[i]    = 16'hFFFF;
            fr[i][0] = 1'b0;
            for (int b = 0; b < DB[i]; b++) fr[i][1+b] = w[b];
            nb = 1 + DB[i];
            if (PAR[i] != 0) begin
                fr[i][nb] = (^w) ^ (PAR[i] == 2);
                nb++;
            end
            nb        = nb + SB[i];
            fr_tot[i] = nb * CPB;
            fr_cyc[i] = 0;
        end
        if (v && rdy) begin
            mq[i][mq_n[i]] = d & mask;
            mq_n[i]++;
        end
    endfunction

    function automatic logic exp_line(input int i);
        if (fr_cyc[i] < fr_tot[i]) return fr[i][fr_cyc[i] / CPB];
        return 1'b1;
    endfunction

    // One clock: advance the model on the posedge, compare everything on the negedge
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (rst) model_clear();
            else     model_edge(i, valid[i], data[i]);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("line[%0d]", i),  32'(tx[i]),    32'(exp_line(i)));
            chk($sformatf("busy[%0d]", i),  32'(busy[i]),  32'((fr_cyc[i] < fr_tot[i]) || (mq_n[i] != 0)));
            chk($sformatf("count[%0d]", i), 32'(cnt[i]),   32'(mq_n[i]));
            chk($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(mq_n[i] != DEPTH));
        end
    endtask

    task automatic push_words(input int k, input int n, input int base, output int bc, output int saw_full);
        int acc = 0;
        int guard = 0;
        logic r;
        bc = 0;
        saw_full = 0;
        while (acc < n && guard < 300) begin
            data[k]  = 9'(base + acc);
            valid[k] = 1'b1;
            r        = ready[k];
            step();
            if (busy[k]) bc++;
            if (r) acc++;
            if (!ready[k] && cnt[k] == 3'(DEPTH)) saw_full = 1;
            guard++;
        end
        valid[k] = 1'b0;
        if (acc < n) chk("push_timeout", 32'(acc), 32'(n));
    endtask

    task automatic run_idle(input int k, inout int bc);
        int guard = 0;
        while (busy[k] && guard < 1000) begin
            step();
            if (busy[k]) bc++;
            guard++;
        end
        if (busy[k]) chk("idle_timeout", 32'(busy[k]), 32'(0));
    endtask

    logic ln [NI][64];
    int   bcnt [NI];
    int   bc, full, guard;
    logic [9:0] pat;

    initial begin
        rst   = 1'b1;
        valid = '0;
        data  = '0;
        model_clear();
        repeat (2) step();
        chk("rst_line", 32'(tx[0]), 32'(1));
        chk("rst_ready", 32'(ready[0]), 32'(1));
        rst = 1'b0;
        step();

        // Single frames in all four formats at once
        data[0] = 9'h0A5;
        data[1] = 9'h007;
        data[2] = 9'h007;
        data[3] = 9'h055;
        valid   = '1;
        step();
        valid = '0;
        for (int i = 0; i < NI; i++) bcnt[i] = int'(busy[i]);
        for (int s = 1; s <= 60; s++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                ln[i][s] = tx[i];
                if (busy[i]) bcnt[i]++;
            end
        end
        pat = 10'b1101001010;
        for (int j = 0; j < 10; j++) chk($sformatf("a5_bit%0d", j), 32'(ln[0][4*j+2]), 32'(pat[j]));
        chk("even_parity", 32'(ln[1][38]), 32'(1));
        chk("odd_parity",  32'(ln[2][38]), 32'(0));
        chk("frame_len8n1", 32'(bcnt[0] - 1), 32'(40));
        chk("frame_len8e1", 32'(bcnt[1] - 1), 32'(44));
        chk("frame_len8o1", 32'(bcnt[2] - 1), 32'(44));
        chk("frame_len7n2", 32'(bcnt[3] - 1), 32'(40));
        chk("stop2_busy_end", 32'(ln[3][40]), 32'(1));

        // Six words with valid held: backpressure, then back-to-back frames
        push_words(0, 6, 1, bc, full);
        chk("t3_ready_drop", 32'(full), 32'(1));
        run_idle(0, bc);
        chk("t3_busy_cycles", 32'(bc), 32'(241));

        // Full FIFO, offer a word on the edge that pops
        push_words(0, 5, 'h11, bc, full);
        chk("t6_full", 32'(cnt[0]), 32'(4));
        guard = 0;
        while (fr_cyc[0] != fr_tot[0] - 1 && guard < 100) begin
            step();
            guard++;
        end
        chk("t6_ready_low", 32'(ready[0]), 32'(0));
        data[0]  = 9'h0EE;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        chk("t6_count_4to3", 32'(cnt[0]), 32'(3));
        run_idle(0, bc);

        // Async reset mid-frame with two words queued
        push_words(0, 3, 'h3C, bc, full);
        guard = 0;
        while (fr_cyc[0] != 12 && guard < 100) begin
            step();
            guard++;
        end
        chk("t5_queued", 32'(cnt[0]), 32'(2));
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk("t5_line_now", 32'(tx[0]), 32'(1));
        chk("t5_count_now", 32'(cnt[0]), 32'(0));
        chk("t5_busy_now", 32'(busy[0]), 32'(0));
        step();
        rst = 1'b0;
        repeat (60) step();
        chk("t5_no_frames", 32'(tx[0]), 32'(1));

        // Random traffic on all formats
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NI; i++) begin
                valid[i] = ($urandom_range(0, 2) == 0);
                data[i]  = 9'($urandom);
            end
            step();
        end
        valid = '0;
        for (int i = 0; i < NI; i++) run_idle(i, bc);
        for (int i = 0; i < NI; i++) chk($sformatf("final_idle[%0d]", i), 32'(busy[i]), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
